// File: rtl/ets_delay_sequencer.sv
// rtl/ets_delay_sequencer.sv - equivalent-time sampling delay sweep sequencer
//
// Steps a clock generator's dynamic-delay code from first_code towards
// last_code. For each code it waits for PLL lock, requires a settled lock
// window, then requests one capture.
//
// Ports:
//   ref_clk      sole clock, rising edge
//   reset        synchronous, active-high
//   start        one-cycle sweep request (IDLE only)
//   abort        level, returns to IDLE from any active state
//   first_code   first delay code of the sweep
//   last_code    last permitted delay code
//   step         code increment per point (0 behaves as 1)
//   lock         PLL lock, asynchronous to ref_clk
//   capture_ack  one-cycle acknowledge from the capture engine
//   delay        registered delay code to the clock generator
//   capture_req  registered capture request
//   busy         high whenever not IDLE
//   done         one-cycle pulse at sweep completion
//   point_count  acknowledged points in current/last sweep, saturating
//   lock_lost    sticky, lock fell during SETTLE or CAPTURE
//   timeout      sticky, no lock within LOCK_TIMEOUT cycles
module ets_delay_sequencer #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] first_code,
  input  logic [7:0] last_code,
  input  logic [7:0] step,
  input  logic       lock,
  input  logic       capture_ack,
  output logic [7:0] delay,
  output logic       capture_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] point_count,
  output logic       lock_lost,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT_LOCK,
    S_SETTLE,
    S_CAPTURE,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [15:0] SETTLE_LIM  = 16'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_LIM = 16'(LOCK_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        lock_meta;
  logic        lock_s;
  logic [7:0]  last_q;
  logic [7:0]  step_q;
  logic [15:0] wait_cnt;
  logic [15:0] settle_cnt;
  logic [8:0]  next_sum;
  logic        past_last;
  logic        abort_hit;
  logic        start_hit;
  logic        capture_req_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  // Nine-bit sum so a step past 0xFF is seen as beyond last_code, not a wrap.
  assign next_sum  = {1'b0, delay} + {1'b0, step_q};
  assign past_last = next_sum > {1'b0, last_q};
  assign abort_hit = (state != S_IDLE) && abort;
  assign start_hit = (state == S_IDLE) && start;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start) next_state = S_APPLY;
        S_APPLY:     next_state = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s)                      next_state = S_SETTLE;
          else if (wait_cnt == TIMEOUT_LIM) next_state = S_IDLE;
        end
        // The SETTLE entry cycle is not counted: the window is SETTLE_CYCLES
        // locked cycles after the first SETTLE cycle.
        S_SETTLE: begin
          if (!lock_s)                      next_state = S_WAIT_LOCK;
          else if (settle_cnt == SETTLE_LIM) next_state = S_CAPTURE;
        end
        // Loss of lock wins over a simultaneous acknowledge; the point is retried.
        S_CAPTURE: begin
          if (!lock_s)          next_state = S_WAIT_LOCK;
          else if (capture_ack) next_state = S_ADVANCE;
        end
        S_ADVANCE:   next_state = past_last ? S_DONE : S_APPLY;
        S_DONE:      next_state = S_IDLE;
        default:     next_state = S_IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    capture_req_nxt = 1'b0;
    busy_nxt        = 1'b0;
    done_nxt        = 1'b0;
    capture_req_nxt = (next_state == S_CAPTURE);
    busy_nxt        = (next_state != S_IDLE);
    done_nxt        = (next_state == S_DONE);
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      capture_req <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      capture_req <= capture_req_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      delay       <= 8'h00;
      point_count <= 8'h00;
      lock_lost   <= 1'b0;
      timeout     <= 1'b0;
      last_q      <= 8'h00;
      step_q      <= 8'h00;
      wait_cnt    <= 16'h0000;
      settle_cnt  <= 16'h0000;
    end else begin
      if (start_hit) begin
        last_q      <= last_code;
        step_q      <= (step == 8'h00) ? 8'h01 : step;
        delay       <= first_code;
        point_count <= 8'h00;
        lock_lost   <= 1'b0;
        timeout     <= 1'b0;
      end
      if (!abort_hit) begin
        case (state)
          S_WAIT_LOCK: if (!lock_s && wait_cnt == TIMEOUT_LIM) timeout <= 1'b1;
          S_SETTLE:    if (!lock_s) lock_lost <= 1'b1;
          S_CAPTURE:   if (!lock_s) lock_lost <= 1'b1;
          S_ADVANCE: begin
            if (point_count != 8'hFF) point_count <= point_count + 8'h01;
            if (!past_last) delay <= next_sum[7:0];
          end
          default: ;
        endcase
      end
      // Counters restart on every entry into their state.
      wait_cnt   <= (state == S_WAIT_LOCK && next_state == S_WAIT_LOCK) ?
                    wait_cnt + 16'h0001 : 16'h0000;
      settle_cnt <= (state == S_SETTLE && next_state == S_SETTLE) ?
                    settle_cnt + 16'h0001 : 16'h0000;
    end
  end

endmodule

// File: tb/tb_ets_delay_sequencer.sv
// tb/tb_ets_delay_sequencer.sv - directed self-checking bench for ets_delay_sequencer
module tb_ets_delay_sequencer;

  localparam int SETTLE = 8;
  localparam int LTO    = 16;

  logic       ref_clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] first_code;
  logic [7:0] last_code;
  logic [7:0] step;
  logic       lock;
  logic       capture_ack;
  logic [7:0] delay;
  logic       capture_req;
  logic       busy;
  logic       done;
  logic [7:0] point_count;
  logic       lock_lost;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int codes[$];
  int gaps[$];
  int n_req;
  int n_done;

  ets_delay_sequencer #(.SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(LTO)) dut (
    .ref_clk(ref_clk), .reset(reset), .start(start), .abort(abort),
    .first_code(first_code), .last_code(last_code), .step(step),
    .lock(lock), .capture_ack(capture_ack), .delay(delay),
    .capture_req(capture_req), .busy(busy), .done(done),
    .point_count(point_count), .lock_lost(lock_lost), .timeout(timeout)
  );

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_at(input int i);
    return (i < codes.size()) ? codes[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_delay"}, delay, 0);
    expect_eq({tag, "_req"}, capture_req, 0);
    expect_eq({tag, "_busy"}, busy, 0);
    expect_eq({tag, "_done"}, done, 0);
    expect_eq({tag, "_count"}, point_count, 0);
    expect_eq({tag, "_lost"}, lock_lost, 0);
    expect_eq({tag, "_tmo"}, timeout, 0);
  endtask

  // Starts a sweep and plays the capture engine (ack two cycles after each
  // request rise). Inputs are scrambled after start and a stray start is
  // pulsed mid-sweep; both must be ignored.
  task automatic run_sweep(input int max_cyc, input int drop_code,
                           input int abort_req, input int rst_req);
    int cyc, pend, drop_t, last_chg, prev_delay;
    bit prev_req, seen_busy, fin, abort_now, rst_now, ack_chk, abort_chk, rst_chk;
    cyc = 0; pend = 0; drop_t = -100;
    prev_req = 0; seen_busy = 0; fin = 0;
    abort_now = 0; rst_now = 0; ack_chk = 0; abort_chk = 0; rst_chk = 0;
    n_req = 0; n_done = 0;
    codes.delete();
    gaps.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    first_code = 8'h00; last_code = 8'hFF; step = 8'h01;
    last_chg = 0;
    prev_delay = int'(delay);
    while (!fin && cyc < max_cyc) begin
      if (ack_chk) expect_eq("req_low_after_ack", capture_req, 0);
      if (abort_chk) begin
        expect_eq("abort_req_low", capture_req, 0);
        expect_eq("abort_idle", busy, 0);
      end
      if (rst_chk) check_reset_outputs("midsweep_reset");
      ack_chk = 0; abort_chk = 0; rst_chk = 0;
      if (int'(delay) != prev_delay) begin
        last_chg = cyc;
        prev_delay = int'(delay);
        if (int'(delay) == drop_code) drop_t = cyc + 7;
      end
      if (capture_req && !prev_req) begin
        n_req++;
        codes.push_back(int'(delay));
        gaps.push_back(cyc - last_chg);
        pend = 2;
        if (n_req == abort_req) abort_now = 1;
        if (n_req == rst_req) rst_now = 1;
      end
      prev_req = capture_req;
      if (done) n_done++;
      if (busy) seen_busy = 1;
      else if (seen_busy) fin = 1;
      capture_ack = 1'b0;
      abort = 1'b0;
      start = (cyc == 4);
      if (cyc == drop_t) lock = 1'b0;
      if (cyc == drop_t + 10) lock = 1'b1;
      if (rst_now) begin
        reset = 1'b1; rst_now = 0; rst_chk = 1; pend = 0;
      end else if (abort_now) begin
        abort = 1'b1; abort_now = 0; abort_chk = 1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          capture_ack = 1'b1;
          ack_chk = 1;
        end
      end
      tick();
      cyc++;
      reset = 1'b0;
    end
    start = 1'b0; abort = 1'b0; capture_ack = 1'b0; lock = 1'b1;
    expect_eq("sweep_finished", fin, 1);
  endtask

  task automatic load(input logic [7:0] f, input logic [7:0] l, input logic [7:0] s);
    first_code = f; last_code = l; step = s;
  endtask

  initial begin
    int n;
    int min_gap;
    reset = 1'b1; start = 1'b0; abort = 1'b0; lock = 1'b1; capture_ack = 1'b0;
    load(8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (3) tick();

    // three-point sweep
    load(8'h10, 8'h30, 8'h10);
    run_sweep(300, -1, 0, 0);
    expect_eq("basic_nreq", n_req, 3);
    expect_eq("basic_code0", code_at(0), 'h10);
    expect_eq("basic_code1", code_at(1), 'h20);
    expect_eq("basic_code2", code_at(2), 'h30);
    expect_eq("basic_done", n_done, 1);
    expect_eq("basic_count", point_count, 3);
    expect_eq("basic_delay", delay, 'h30);
    min_gap = 1000;
    foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
    expect_eq("basic_settle_gap", int'(min_gap >= SETTLE + 3), 1);
    expect_eq("basic_flags", {lock_lost, timeout}, 0);
    repeat (3) tick();

    // step overflow past 0xFF
    load(8'hF0, 8'hFF, 8'h20);
    run_sweep(300, -1, 0, 0);
    expect_eq("wrap_nreq", n_req, 1);
    expect_eq("wrap_code0", code_at(0), 'hF0);
    expect_eq("wrap_done", n_done, 1);
    expect_eq("wrap_count", point_count, 1);
    expect_eq("wrap_delay", delay, 'hF0);
    repeat (3) tick();

    // lock drop during SETTLE at code 0x20
    load(8'h10, 8'h30, 8'h10);
    run_sweep(400, 'h20, 0, 0);
    expect_eq("drop_lost", lock_lost, 1);
    expect_eq("drop_nreq", n_req, 3);
    expect_eq("drop_code1", code_at(1), 'h20);
    expect_eq("drop_code2", code_at(2), 'h30);
    expect_eq("drop_resettle", int'(gap_at(1) >= 7 + 10 + SETTLE), 1);
    expect_eq("drop_done", n_done, 1);
    expect_eq("drop_count", point_count, 3);
    expect_eq("drop_tmo", timeout, 0);
    repeat (3) tick();

    // no lock at all: timeout
    lock = 1'b0;
    repeat (4) tick();
    load(8'h10, 8'h30, 8'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1; n_done = 0;
    while (busy && n < 40) begin
      if (done) n_done++;
      tick();
      n++;
    end
    expect_eq("tmo_latency", n, LTO + 2);
    expect_eq("tmo_flag", timeout, 1);
    expect_eq("tmo_nodone", n_done, 0);
    expect_eq("tmo_lost", lock_lost, 0);
    expect_eq("tmo_delay", delay, 'h10);
    expect_eq("tmo_count", point_count, 0);
    lock = 1'b1;
    repeat (4) tick();

    // abort on the second capture request, then a clean sweep
    load(8'h10, 8'h30, 8'h10);
    run_sweep(300, -1, 2, 0);
    expect_eq("abort_nreq", n_req, 2);
    expect_eq("abort_nodone", n_done, 0);
    expect_eq("abort_delay", delay, 'h20);
    expect_eq("abort_count", point_count, 1);
    expect_eq("abort_tmo_cleared", timeout, 0);
    repeat (3) tick();
    load(8'h10, 8'h30, 8'h10);
    run_sweep(300, -1, 0, 0);
    expect_eq("after_abort_nreq", n_req, 3);
    expect_eq("after_abort_done", n_done, 1);
    expect_eq("after_abort_count", point_count, 3);
    expect_eq("after_abort_flags", {lock_lost, timeout}, 0);
    repeat (3) tick();

    // reset while capture_req is high, then step=0 sweep
    load(8'h10, 8'h30, 8'h10);
    run_sweep(300, -1, 0, 2);
    expect_eq("rst_nodone", n_done, 0);
    repeat (4) tick();
    load(8'h05, 8'h07, 8'h00);
    run_sweep(300, -1, 0, 0);
    expect_eq("step0_nreq", n_req, 3);
    expect_eq("step0_code0", code_at(0), 5);
    expect_eq("step0_code1", code_at(1), 6);
    expect_eq("step0_code2", code_at(2), 7);
    expect_eq("step0_done", n_done, 1);
    expect_eq("step0_count", point_count, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
